median9_sort_scheduler: RTL and testbench

//  Computes the median of a 3x3 pixel window by time-multiplexing one shared
//  3-input Sorting_network over a fixed 7-step schedule.

---
 rtl/median9_sort_scheduler_pkg.sv | 23 ++
 rtl/median9_sort_scheduler_sort3.sv | 26 ++
 rtl/median9_sort_scheduler.sv | 155 +++++++++++++++
 tb/tb_median9_sort_scheduler.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/median9_sort_scheduler_pkg.sv
// Shared definitions for the 3x3 median scheduler: FSM encoding, step indices
// of the fixed 7-step sort schedule, and the default pixel width.
package median9_sort_scheduler_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int NUM_STEPS      = 7;
  localparam int STEP_W         = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SORT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [STEP_W-1:0] S_COL0  = 3'd0;
  localparam logic [STEP_W-1:0] S_COL1  = 3'd1;
  localparam logic [STEP_W-1:0] S_COL2  = 3'd2;
  localparam logic [STEP_W-1:0] S_MAXS  = 3'd3;
  localparam logic [STEP_W-1:0] S_MEDS  = 3'd4;
  localparam logic [STEP_W-1:0] S_MINS  = 3'd5;
  localparam logic [STEP_W-1:0] S_FINAL = 3'd6;

endpackage

// File: rtl/median9_sort_scheduler_sort3.sv
// Combinational 3-input unsigned sorting network: three compare-exchange
// stages producing max, median and min.
module median9_sort_scheduler_sort3 #(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] s1,
  input  logic [DATA_WIDTH-1:0] s2,
  input  logic [DATA_WIDTH-1:0] s3,
  output logic [DATA_WIDTH-1:0] max_val,
  output logic [DATA_WIDTH-1:0] med_val,
  output logic [DATA_WIDTH-1:0] min_val
);

  logic [DATA_WIDTH-1:0] lo1, hi1, mid_t;

  always_comb begin
    lo1     = (s1 < s2) ? s1 : s2;
    hi1     = (s1 < s2) ? s2 : s1;
    max_val = (hi1 < s3) ? s3 : hi1;
    mid_t   = (hi1 < s3) ? hi1 : s3;
    // Largest is settled; the remaining two give median and minimum.
    min_val = (lo1 < mid_t) ? lo1 : mid_t;
    med_val = (lo1 < mid_t) ? mid_t : lo1;
  end

endmodule

// File: rtl/median9_sort_scheduler.sv
// 3x3 median filter core: one shared sort3 network stepped through a 7-step
// column/diagonal schedule, with valid/ready handshakes on both sides.
module median9_sort_scheduler
  import median9_sort_scheduler_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int PIPE_SORT  = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [9*DATA_WIDTH-1:0] in_window,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_median,
  output logic                    busy
);

  localparam int DW = DATA_WIDTH;

  state_t            state_reg;
  logic [STEP_W-1:0] step_reg;
  logic              phase_reg;
  logic [DW-1:0]     win_pix     [9];
  logic [DW-1:0]     pix_reg     [9];
  logic [DW-1:0]     col_max_reg [3];
  logic [DW-1:0]     col_med_reg [3];
  logic [DW-1:0]     col_min_reg [3];
  logic [DW-1:0]     a_reg, b_reg, c_reg;
  logic [DW-1:0]     sort_a, sort_b, sort_c;
  logic [DW-1:0]     sort_max, sort_med, sort_min;
  logic [DW-1:0]     res_max, res_med, res_min;

  genvar gi;
  generate
    for (gi = 0; gi < 9; gi++) begin : g_unpack
      assign win_pix[gi] = in_window[gi*DW +: DW];
    end
  endgenerate

  assign in_ready = (state_reg == ST_IDLE) && !rst;
  assign busy     = (state_reg != ST_IDLE);

  always_comb begin
    sort_a = '0;
    sort_b = '0;
    sort_c = '0;
    case (step_reg)
      S_COL0:  begin sort_a = pix_reg[0]; sort_b = pix_reg[3]; sort_c = pix_reg[6]; end
      S_COL1:  begin sort_a = pix_reg[1]; sort_b = pix_reg[4]; sort_c = pix_reg[7]; end
      S_COL2:  begin sort_a = pix_reg[2]; sort_b = pix_reg[5]; sort_c = pix_reg[8]; end
      S_MAXS:  begin sort_a = col_max_reg[0]; sort_b = col_max_reg[1]; sort_c = col_max_reg[2]; end
      S_MEDS:  begin sort_a = col_med_reg[0]; sort_b = col_med_reg[1]; sort_c = col_med_reg[2]; end
      S_MINS:  begin sort_a = col_min_reg[0]; sort_b = col_min_reg[1]; sort_c = col_min_reg[2]; end
      default: begin sort_a = a_reg; sort_b = b_reg; sort_c = c_reg; end
    endcase
  end

  median9_sort_scheduler_sort3 #(.DATA_WIDTH(DW)) u_sort3 (
    .s1      (sort_a),
    .s2      (sort_b),
    .s3      (sort_c),
    .max_val (sort_max),
    .med_val (sort_med),
    .min_val (sort_min)
  );

  generate
    if (PIPE_SORT != 0) begin : g_pipe
      logic [DW-1:0] max_reg, med_reg, min_reg;
      always_ff @(posedge clk) begin
        if (rst) begin
          max_reg <= '0;
          med_reg <= '0;
          min_reg <= '0;
        end else begin
          max_reg <= sort_max;
          med_reg <= sort_med;
          min_reg <= sort_min;
        end
      end
      assign res_max = max_reg;
      assign res_med = med_reg;
      assign res_min = min_reg;
    end else begin : g_comb
      assign res_max = sort_max;
      assign res_med = sort_med;
      assign res_min = sort_min;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      step_reg   <= '0;
      phase_reg  <= 1'b0;
      out_valid  <= 1'b0;
      out_median <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      c_reg      <= '0;
      for (int i = 0; i < 9; i++) pix_reg[i] <= '0;
      for (int i = 0; i < 3; i++) begin
        col_max_reg[i] <= '0;
        col_med_reg[i] <= '0;
        col_min_reg[i] <= '0;
      end
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (in_valid) begin
            for (int i = 0; i < 9; i++) pix_reg[i] <= win_pix[i];
            step_reg  <= '0;
            phase_reg <= 1'b0;
            state_reg <= ST_SORT;
          end
        end
        ST_SORT: begin
          // With a piped sorter, the first cycle of a step only fills the output register.
          if (PIPE_SORT != 0 && !phase_reg) begin
            phase_reg <= 1'b1;
          end else begin
            phase_reg <= 1'b0;
            case (step_reg)
              S_COL0: begin col_max_reg[0] <= res_max; col_med_reg[0] <= res_med; col_min_reg[0] <= res_min; end
              S_COL1: begin col_max_reg[1] <= res_max; col_med_reg[1] <= res_med; col_min_reg[1] <= res_min; end
              S_COL2: begin col_max_reg[2] <= res_max; col_med_reg[2] <= res_med; col_min_reg[2] <= res_min; end
              S_MAXS: a_reg <= res_min;
              S_MEDS: b_reg <= res_med;
              S_MINS: c_reg <= res_max;
              default: begin
                out_median <= res_med;
                out_valid  <= 1'b1;
              end
            endcase
            if (step_reg == S_FINAL) begin
              state_reg <= ST_DONE;
            end else begin
              step_reg <= step_reg + 3'd1;
            end
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state_reg <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_median9_sort_scheduler.sv
// Bench for median9_sort_scheduler: table of directed windows, backpressure,
// mid-window reset, a piped-sorter instance and a randomized scoreboard run.
module tb_median9_sort_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, busy;
  logic [71:0] in_window;
  logic [7:0]  out_median;
  logic        p_in_valid, p_in_ready, p_out_valid, p_out_ready, p_busy;
  logic [71:0] p_in_window;
  logic [7:0]  p_out_median;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  median9_sort_scheduler #(.DATA_WIDTH(8), .PIPE_SORT(0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_window(in_window), .out_valid(out_valid), .out_ready(out_ready),
    .out_median(out_median), .busy(busy)
  );

  median9_sort_scheduler #(.DATA_WIDTH(8), .PIPE_SORT(1)) dut_p (
    .clk(clk), .rst(rst), .in_valid(p_in_valid), .in_ready(p_in_ready),
    .in_window(p_in_window), .out_valid(p_out_valid), .out_ready(p_out_ready),
    .out_median(p_out_median), .busy(p_busy)
  );

  typedef struct {
    logic [71:0] win;
    logic [7:0]  exp;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [71:0] mk(input int v0, input int v1, input int v2,
                                     input int v3, input int v4, input int v5,
                                     input int v6, input int v7, input int v8);
    return {v8[7:0], v7[7:0], v6[7:0], v5[7:0], v4[7:0],
            v3[7:0], v2[7:0], v1[7:0], v0[7:0]};
  endfunction

  // Reference: sort all nine pixels and take the middle element.
  function automatic logic [7:0] model_median(input logic [71:0] w);
    int a [9];
    int t;
    for (int i = 0; i < 9; i++) a[i] = int'(w[i*8 +: 8]);
    for (int i = 0; i < 9; i++)
      for (int j = 0; j < 8 - i; j++)
        if (a[j] > a[j+1]) begin
          t = a[j]; a[j] = a[j+1]; a[j+1] = t;
        end
    return 8'(a[4]);
  endfunction

  function automatic logic [7:0] rand_pix();
    case ($urandom_range(0, 3))
      0:       return 8'd0;
      1:       return 8'd255;
      default: return 8'($urandom);
    endcase
  endfunction

  function automatic logic cur_in_ready(input bit pipe);
    return pipe ? p_in_ready : in_ready;
  endfunction

  function automatic logic cur_out_valid(input bit pipe);
    return pipe ? p_out_valid : out_valid;
  endfunction

  // Accept one window, measure latency to out_valid, check median; optionally
  // complete the output handshake (out_ready assumed high in that case).
  task automatic send_check(input bit pipe, input logic [71:0] win, input logic [7:0] exp,
                            input int exp_lat, input string name, input bit release_out);
    int  n;
    bit  ready_low;
    n = 0;
    while (!cur_in_ready(pipe) && n < 50) begin tick(); n++; end
    chk({name, " in_ready_before"}, 32'(cur_in_ready(pipe)), 1);
    if (pipe) begin p_in_valid = 1'b1; p_in_window = win; end
    else      begin in_valid   = 1'b1; in_window   = win; end
    tick();
    if (pipe) begin p_in_valid = 1'b0; p_in_window = {$urandom, $urandom, 8'($urandom)}; end
    else      begin in_valid   = 1'b0; in_window   = {$urandom, $urandom, 8'($urandom)}; end
    ready_low = 1'b1;
    n = 0;
    while (!cur_out_valid(pipe) && n < 40) begin
      if (cur_in_ready(pipe)) ready_low = 1'b0;
      tick();
      n++;
    end
    chk({name, " latency"}, 32'(n), 32'(exp_lat));
    chk({name, " in_ready_low"}, 32'(ready_low), 1);
    chk({name, " median"}, 32'(pipe ? p_out_median : out_median), 32'(exp));
    if (release_out) begin
      tick();
      chk({name, " out_valid_drop"}, 32'(cur_out_valid(pipe)), 0);
    end
    $display("window %s: median=%0d expected=%0d latency=%0d", name,
             pipe ? p_out_median : out_median, exp, n);
  endtask

  initial begin
    logic [7:0] q[$];
    int  recv;
    bit  never_valid;

    vecs[0] = '{mk(9, 1, 8, 2, 7, 3, 6, 4, 5), 8'd5};
    vecs[1] = '{mk(128, 128, 128, 128, 128, 128, 128, 128, 128), 8'h80};
    vecs[2] = '{mk(0, 0, 0, 0, 255, 255, 255, 255, 1), 8'd1};
    vecs[3] = '{mk(255, 255, 255, 255, 255, 255, 255, 255, 255), 8'd255};
    vecs[4] = '{mk(5, 5, 5, 1, 1, 1, 9, 9, 9), 8'd5};
    vecs[5] = '{mk(8, 7, 6, 5, 4, 3, 2, 1, 0), 8'd4};
    vecs[6] = '{mk(0, 0, 0, 0, 0, 200, 200, 200, 200), 8'd0};

    rst = 1'b1;
    in_valid = 1'b0; in_window = '0; out_ready = 1'b1;
    p_in_valid = 1'b0; p_in_window = '0; p_out_ready = 1'b1;
    repeat (3) tick();
    chk("reset in_ready", 32'(in_ready), 0);
    chk("reset busy", 32'(busy), 0);
    chk("reset out_valid", 32'(out_valid), 0);
    chk("reset out_median", 32'(out_median), 0);
    chk("reset p_in_ready", 32'(p_in_ready), 0);
    rst = 1'b0;
    #1;
    chk("post-reset in_ready", 32'(in_ready), 1);
    tick();

    for (int i = 0; i < 7; i++)
      send_check(1'b0, vecs[i].win, vecs[i].exp, 7, $sformatf("vec%0d", i), 1'b1);

    // Backpressure: hold the result in DONE for five cycles.
    out_ready = 1'b0;
    send_check(1'b0, mk(3, 9, 4, 7, 1, 8, 2, 6, 5), 8'd5, 7, "bp", 1'b0);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp out_valid", 32'(out_valid), 1);
      chk("bp out_median", 32'(out_median), 5);
      chk("bp in_ready", 32'(in_ready), 0);
    end
    out_ready = 1'b1;
    tick();
    chk("bp release out_valid", 32'(out_valid), 0);
    chk("bp release in_ready", 32'(in_ready), 1);
    $display("window bp: released after hold");

    // Reset arriving while step 3 is pending aborts the window.
    in_valid = 1'b1; in_window = mk(200, 100, 50, 25, 12, 6, 3, 1, 0);
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    #1;
    chk("abort rst in_ready", 32'(in_ready), 0);
    tick();
    rst = 1'b0;
    chk("abort out_valid", 32'(out_valid), 0);
    chk("abort out_median", 32'(out_median), 0);
    chk("abort busy", 32'(busy), 0);
    #1;
    chk("abort in_ready", 32'(in_ready), 1);
    never_valid = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (out_valid) never_valid = 1'b0;
    end
    chk("abort no out_valid", 32'(never_valid), 1);
    $display("window abort: reset at step 3");
    send_check(1'b0, mk(1, 2, 3, 4, 5, 6, 7, 8, 9), 8'd5, 7, "after_abort", 1'b1);

    send_check(1'b1, mk(10, 20, 15, 50, 30, 40, 5, 25, 15), 8'd20, 14, "pipe", 1'b1);

    // Randomized run with gaps on both handshakes, checked in order.
    recv = 0;
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          automatic logic [71:0] w;
          automatic bit acc = 1'b0;
          automatic int n = 0;
          repeat ($urandom_range(0, 3)) tick();
          for (int k = 0; k < 9; k++) w[k*8 +: 8] = rand_pix();
          in_valid = 1'b1; in_window = w;
          while (!acc && n < 200) begin acc = in_ready; tick(); n++; end
          in_valid = 1'b0;
          in_window = {$urandom, $urandom, 8'($urandom)};
          if (acc) q.push_back(model_median(w));
          else chk("rand accept timeout", 0, 1);
        end
      end
      begin
        automatic int cyc = 0;
        automatic logic [7:0] e;
        while (recv < 1000 && cyc < 60000) begin
          out_ready = 1'($urandom_range(0, 1));
          if (out_valid && out_ready) begin
            if (q.size() == 0) begin
              chk("rand unexpected output", 1, 0);
            end else begin
              e = q.pop_front();
              chk("rand median", 32'(out_median), 32'(e));
              $display("rand %0d: median=%0d expected=%0d", recv, out_median, e);
            end
            recv++;
          end
          tick();
          cyc++;
        end
      end
    join
    out_ready = 1'b1;
    chk("rand received count", 32'(recv), 1000);
    chk("rand queue empty", 32'(q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
